multi_dispatcher: RTL

Parametrised successor of the 3-counter fixed-priority dispatcher. Pops the head entry {ID, service time} from the customer queue FIFO and loads it into one idle service counter out of N_CNT. Arbitration is fixed-priority or round-robin, selected at run time. Adds a per-channel enable mask, zero-time entry drop, a load-to-busy hazard guard and a FIFO read hold-off. Sits between the queue FIFO and the bank of service counters.

---
 rtl/multi_dispatcher.sv | 109 ++++++++++
 1 files changed

// File: rtl/multi_dispatcher.sv
// Dispatches the queue FIFO head {ID, time} into one idle service counter out of N_CNT
// (fixed-priority or round-robin); optional saturating grant/drop counters via DISPATCH_STATS_EN.
module multi_dispatcher #(
   parameter int N_CNT  = 3,
   parameter int ID_W   = 4,
   parameter int TIME_W = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [N_CNT-1:0]          ch_mask,
   input  logic                      empty,
   input  logic [ID_W-1:0]           qn,
   input  logic [TIME_W-1:0]         qt,
   input  logic [N_CNT-1:0]          busy,
   output logic                      re,
   output logic [N_CNT-1:0]          ld,
   output logic [N_CNT*ID_W-1:0]     dn,
   output logic [N_CNT*TIME_W-1:0]   dt,
   output logic                      drop,
   output logic                      stall,
   output logic [$clog2(N_CNT)-1:0]  last_ch
`ifdef DISPATCH_STATS_EN
   ,
   output logic [15:0]               disp_cnt,
   output logic [15:0]               drop_cnt
`endif
);

   localparam int PTR_W = $clog2(N_CNT);

   logic [N_CNT-1:0] elig;
   logic             action;
   logic             gnt_vld;
   logic [PTR_W-1:0] gnt_idx;
   logic [PTR_W-1:0] rr_nxt;
   logic [PTR_W-1:0] rr_ptr;
   int               c;

   // Last cycle's ld masks its channel until the counter has had time to raise busy.
   assign elig   = ch_mask & ~busy & ~ld;
   assign action = !empty && !re;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      c       = 0;
      if (!mode) begin
         for (int k = N_CNT-1; k >= 0; k--) begin
            if (elig[k]) begin
               gnt_vld = 1'b1;
               gnt_idx = PTR_W'(k);
            end
         end
      end else begin
         // Descending scan so the last hit is the first channel at or after rr_ptr.
         for (int k = N_CNT-1; k >= 0; k--) begin
            c = (int'(rr_ptr) + k) % N_CNT;
            if (elig[c]) begin
               gnt_vld = 1'b1;
               gnt_idx = PTR_W'(c);
            end
         end
      end
      rr_nxt = (int'(gnt_idx) == N_CNT-1) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         re      <= 1'b0;
         ld      <= '0;
         dn      <= '0;
         dt      <= '0;
         drop    <= 1'b0;
         stall   <= 1'b0;
         last_ch <= '0;
         rr_ptr  <= '0;
`ifdef DISPATCH_STATS_EN
         disp_cnt <= '0;
         drop_cnt <= '0;
`endif
      end else begin
         re    <= 1'b0;
         ld    <= '0;
         drop  <= 1'b0;
         stall <= action && (qt != '0) && !gnt_vld;
         if (action) begin
            if (qt == '0) begin
               re   <= 1'b1;
               drop <= 1'b1;
`ifdef DISPATCH_STATS_EN
               if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`endif
            end else if (gnt_vld) begin
               re                            <= 1'b1;
               ld[gnt_idx]                   <= 1'b1;
               dn[gnt_idx*ID_W +: ID_W]      <= qn;
               dt[gnt_idx*TIME_W +: TIME_W]  <= qt;
               last_ch                       <= gnt_idx;
               if (mode) rr_ptr <= rr_nxt;
`ifdef DISPATCH_STATS_EN
               if (disp_cnt != 16'hFFFF) disp_cnt <= disp_cnt + 16'd1;
`endif
            end
         end
      end
   end

endmodule
